// File: rtl/optical_link_pkg.sv
// optical_link_pkg: shared framing constants, FSM/word-class encodings and the
// 48-bit PRBS step used by both ends of the 2-lane optical PRBS link.
// Contents: BOND/START/DATA framing words and K masks, PRBS seed, prbs48_next(), classify_word().
package optical_link_pkg;

  localparam logic [63:0] BOND_WORD  = {8'h1C, 8'hFE, 8'hFB, 8'hDC, 32'h0};
  localparam logic [7:0]  BOND_K     = 8'h0F;
  localparam logic [63:0] START_WORD = 64'hFCFC_FCFC_FCFC_FCFC;
  localparam logic [7:0]  START_K    = 8'hFF;
  localparam logic [15:0] COMMA16    = 16'hBC50;
  localparam logic [7:0]  DATA_K     = 8'h03;

  // Generator state after reset; it is also the first payload word emitted.
  localparam logic [47:0] PRBS_SEED  = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_BOND       = 2'd0,
    ST_WAIT_START = 2'd1,
    ST_CHECK      = 2'd2
  } rx_state_e;

  typedef enum logic [2:0] {
    WC_BOND,
    WC_START,
    WC_DATA,
    WC_IDLE,
    WC_FRAME
  } word_class_e;

  // One word step = 48 shifts of the Fibonacci LFSR x^48+x^47+x^21+x^20+1,
  // so consecutive payload words carry non-overlapping slices of the bit stream
  // (oldest bit at [47]).
  function automatic logic [47:0] prbs48_next(input logic [47:0] cur);
    logic [47:0] s;
    s = cur;
    for (int i = 0; i < 48; i++) begin
      s = {s[46:0], s[47] ^ s[46] ^ s[20] ^ s[19]};
    end
    return s;
  endfunction

  function automatic word_class_e classify_word(input logic [63:0] d, input logic [7:0] k);
    word_class_e c;
    if (d == BOND_WORD && k == BOND_K)              c = WC_BOND;
    else if (d == START_WORD && k == START_K)       c = WC_START;
    else if (d[15:0] == COMMA16 && k == DATA_K)     c = WC_DATA;
    else if (d == 64'h0 && k == 8'h00)              c = WC_IDLE;
    else                                            c = WC_FRAME;
    return c;
  endfunction

endpackage

// File: rtl/prbs48_ref_gen.sv
// prbs48_ref_gen: local copy of the transmitter's 48-bit PRBS word generator.
// Latency: ref_o is registered; seed/advance take effect on the next cycle. No backpressure.
// Ports: clock, reset (sync, high), seed_i (reload seed, wins over advance), advance_i (one word step), ref_o (current word).
module prbs48_ref_gen
  import optical_link_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        seed_i,
  input  logic        advance_i,
  output logic [47:0] ref_o
);

  logic [47:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (seed_i)         lfsr_d = PRBS_SEED;
    else if (advance_i) lfsr_d = prbs48_next(lfsr_q);
  end

  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= PRBS_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign ref_o = lfsr_q;

endmodule

// File: rtl/optical_rx_prbs_checker.sv
// optical_rx_prbs_checker: RX-side framing tracker and PRBS checker with error counters.
// Latency: flags/counters update 1 cycle after the accepted word. Backpressure: none; rx_valid=0 freezes state.
// Ports: clock/reset (sync, high); rx_valid/rx_data/rx_iskchar word input; clear_counters;
//   bonded, locked, word_err pulse, bit_err_cnt, word_err_cnt, word_cnt, resync_cnt, state.
// Optional: define OPTICAL_RX_ERR_CAPTURE_EN to add first_err_exp/first_err_got/first_err_valid.
module optical_rx_prbs_checker
  import optical_link_pkg::*;
#(
  parameter int BOND_MIN    = 16,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [63:0]      rx_data,
  input  logic [7:0]       rx_iskchar,
  input  logic             clear_counters,
  output logic             bonded,
  output logic             locked,
  output logic             word_err,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic [CNT_W-1:0] word_err_cnt,
  output logic [47:0]      word_cnt,
  output logic [15:0]      resync_cnt,
  output logic [1:0]       state
`ifdef OPTICAL_RX_ERR_CAPTURE_EN
  ,
  output logic [47:0]      first_err_exp,
  output logic [47:0]      first_err_got,
  output logic             first_err_valid
`endif
);

  localparam int BW = $clog2(BOND_MIN + 1);
  localparam int RW = $clog2(LOSS_THRESH + 1);
  localparam logic [BW-1:0] BOND_LAST = BW'(BOND_MIN - 1);
  localparam logic [RW-1:0] RUN_LAST  = RW'(LOSS_THRESH - 1);

  rx_state_e        state_q, state_d;
  word_class_e      cls;
  logic [47:0]      ref_word, diff;
  logic [5:0]       pop;
  logic             in_wait, in_check;
  logic             data_chk, start_wait, start_chk, reseed, clean_now, err_now;
  logic [BW-1:0]    bond_cnt_q, bond_cnt_d;
  logic [RW-1:0]    err_run_q, err_run_d;
  logic             bonded_q, bonded_d;
  logic             word_err_q;
  logic [CNT_W-1:0] bit_err_q, bit_err_d;
  logic [CNT_W-1:0] werr_cnt_q, werr_cnt_d;
  logic [CNT_W:0]   bit_sum;
  logic [47:0]      word_cnt_q, word_cnt_d;
  logic [15:0]      resync_q, resync_d;

  assign cls      = classify_word(rx_data, rx_iskchar);
  assign in_wait  = rx_valid && (state_q == ST_WAIT_START);
  assign in_check = rx_valid && (state_q == ST_CHECK);

  assign diff = rx_data[63:16] ^ ref_word;
  assign pop  = 6'($countones(diff));

  assign data_chk   = in_check && (cls == WC_DATA);
  assign start_wait = in_wait && (cls == WC_START);
  assign start_chk  = in_check && (cls == WC_START);
  assign reseed     = start_wait || start_chk;
  // In CHECK every accepted word is either clean (START or matching DATA) or a word error.
  assign clean_now  = start_chk || (data_chk && (diff == 48'h0));
  assign err_now    = in_check && !clean_now;

  prbs48_ref_gen u_ref (
    .clock     (clock),
    .reset     (reset),
    .seed_i    (reseed),
    .advance_i (data_chk),
    .ref_o     (ref_word)
  );

  // FSM: state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_BOND;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOND:       if (rx_valid && cls == WC_BOND && bond_cnt_q == BOND_LAST) state_d = ST_WAIT_START;
      ST_WAIT_START: if (start_wait) state_d = ST_CHECK;
      ST_CHECK:      if (err_now && err_run_q == RUN_LAST) state_d = ST_WAIT_START;
      default:       state_d = ST_BOND;
    endcase
  end

  // FSM: outputs
  always_comb begin
    locked = (state_q == ST_CHECK);
  end

  // Bond counter, consecutive-error run and sticky bonded flag.
  always_comb begin
    bond_cnt_d = bond_cnt_q;
    if (rx_valid && state_q == ST_BOND) begin
      if (cls == WC_BOND)      bond_cnt_d = (bond_cnt_q == BOND_LAST) ? '0 : bond_cnt_q + 1'b1;
      else if (cls != WC_IDLE) bond_cnt_d = '0;
    end
    err_run_d = err_run_q;
    if (in_check) err_run_d = (!err_now || err_run_q == RUN_LAST) ? '0 : err_run_q + 1'b1;
    bonded_d = bonded_q || (state_q == ST_BOND && state_d == ST_WAIT_START);
  end

  // Counters; clear_counters overrides any same-cycle update.
  always_comb begin
    bit_err_d  = bit_err_q;
    werr_cnt_d = werr_cnt_q;
    word_cnt_d = word_cnt_q;
    resync_d   = resync_q;
    bit_sum    = {1'b0, bit_err_q} + {{(CNT_W - 5){1'b0}}, pop};
    if (data_chk) begin
      word_cnt_d = word_cnt_q + 48'd1;
      bit_err_d  = bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    end
    if (err_now && werr_cnt_q != '1) werr_cnt_d = werr_cnt_q + 1'b1;
    if (reseed && resync_q != 16'hFFFF) resync_d = resync_q + 16'd1;
    if (clear_counters) begin
      bit_err_d  = '0;
      werr_cnt_d = '0;
      word_cnt_d = '0;
      resync_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bond_cnt_q <= '0;
      err_run_q  <= '0;
      bonded_q   <= 1'b0;
      word_err_q <= 1'b0;
      bit_err_q  <= '0;
      werr_cnt_q <= '0;
      word_cnt_q <= '0;
      resync_q   <= '0;
    end else begin
      bond_cnt_q <= bond_cnt_d;
      err_run_q  <= err_run_d;
      bonded_q   <= bonded_d;
      word_err_q <= err_now;
      bit_err_q  <= bit_err_d;
      werr_cnt_q <= werr_cnt_d;
      word_cnt_q <= word_cnt_d;
      resync_q   <= resync_d;
    end
  end

  assign bonded       = bonded_q;
  assign word_err     = word_err_q;
  assign bit_err_cnt  = bit_err_q;
  assign word_err_cnt = werr_cnt_q;
  assign word_cnt     = word_cnt_q;
  assign resync_cnt   = resync_q;
  assign state        = state_q;

`ifdef OPTICAL_RX_ERR_CAPTURE_EN
  logic        cap_vld_q, cap_vld_d;
  logic [47:0] cap_exp_q, cap_exp_d, cap_got_q, cap_got_d;

  // Holds the first PRBS mismatch only; re-armed by clear_counters.
  always_comb begin
    cap_vld_d = cap_vld_q;
    cap_exp_d = cap_exp_q;
    cap_got_d = cap_got_q;
    if (data_chk && diff != 48'h0 && !cap_vld_q) begin
      cap_vld_d = 1'b1;
      cap_exp_d = ref_word;
      cap_got_d = rx_data[63:16];
    end
    if (clear_counters) begin
      cap_vld_d = 1'b0;
      cap_exp_d = '0;
      cap_got_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cap_vld_q <= 1'b0;
      cap_exp_q <= '0;
      cap_got_q <= '0;
    end else begin
      cap_vld_q <= cap_vld_d;
      cap_exp_q <= cap_exp_d;
      cap_got_q <= cap_got_d;
    end
  end

  assign first_err_valid = cap_vld_q;
  assign first_err_exp   = cap_exp_q;
  assign first_err_got   = cap_got_q;
`endif

endmodule
